env_gen: RTL and testbench
==========================

// Module: env_gen
// PURPOSE
//  Bank of NUM_UNITS independent linear ADSR envelope generators, one per synth voice.
//  Each unit is gated by its trigger bit and produces an EG_WIDTH-bit amplitude
//  envelope for the voice's VCA. in_use flags the voices still sounding, for voice allocation.
// PARAMETERS
//  EG_WIDTH   8  width of each rate/level field and of each envelope output
//  NUM_UNITS  4  number of independent envelope units
// PORTS
//  aud_clk     in   1                   audio clock; all state changes on its rising edge
//  aud_rst     in   1                   asynchronous active-low reset
//  attack_in   in   EG_WIDTH*NUM_UNITS  per-unit attack rate; unit i = bits [EG_WIDTH*(i+1)-1:EG_WIDTH*i]
//  decay_in    in   EG_WIDTH*NUM_UNITS  per-unit decay rate (same packing)
//  sustain_in  in   EG_WIDTH*NUM_UNITS  per-unit sustain level (same packing)
//  release_in  in   EG_WIDTH*NUM_UNITS  per-unit release rate (same packing)
//  trigger     in   NUM_UNITS           gate per unit: 1 = key held, 0 = key released
//  in_use      out  NUM_UNITS           1 while unit i is in any state other than IDLE
//  env_out     out  EG_WIDTH*NUM_UNITS  per-unit envelope level (same packing)
// BEHAVIOUR
//  - Per unit: acc[2*EG_WIDTH-1:0]; trig_q (registered trigger); state IDLE/ATTACK/DECAY/SUSTAIN/RELEASE.
//  - env_out slice = acc[2W-1:W], where W = EG_WIDTH. in_use = (state != IDLE). Both registered.
//  - Reset (aud_rst=0): state=IDLE, acc=0, trig_q=0, env_out=0, in_use=0. Holds while low.
//  - Rate R to step per clock: step = 2^W - R (R=0 fastest: 2^W; R=2^W-1 slowest: 1).
//  - Edge detect: rise = trigger & ~trig_q; fall = ~trigger & trig_q. The state change takes
//    effect on the edge that sees the event. acc begins moving on the following edge.
//  - IDLE: acc holds 0. On rise, go to ATTACK.
//  - ATTACK: acc += step(attack). On saturation (sum >= 2^(2W)-1), acc = all-ones and go to DECAY.
//  - DECAY: target = {sustain, W'hFF..}. If acc - step(decay) <= target, acc = target and go to SUSTAIN.
//    Otherwise acc -= step(decay). If acc <= target on entry, go straight to SUSTAIN.
//  - SUSTAIN: acc = {sustain_in, all-ones}; it tracks live sustain_in changes.
//  - RELEASE: acc -= step(release). If acc < step, acc = 0 and go to IDLE.
//  - fall in ATTACK/DECAY/SUSTAIN: go to RELEASE from the current acc (no jump).
//  - rise in RELEASE/DECAY/SUSTAIN (retrigger): go to ATTACK; the start level depends on the macro.
//  - rise and fall cannot coincide. trigger held high and steady never retriggers.
//  - Rate and sustain inputs are sampled every cycle. A change applies on the next step.
//  - Units are fully independent. No cross-unit interaction.
// CONFIGURATION
//  ENV_GEN_LEGATO_EN defined: retrigger keeps the current acc and attacks from there.
//  Undefined (default): retrigger clears acc to 0 on the same edge that enters ATTACK.
//  IDLE->ATTACK behaves the same in both builds (acc is already 0).
// TESTING
//  1 Reset: aud_rst=0 with trigger=4'hF -> env_out=0, in_use=0. After release of reset, units start.
//  2 attack=8'h80, decay=8'h80, sustain=8'h1F, trigger 0->1
//      -> in_use=1; env_out=8'hFF after 512 attack cycles;
//      -> then about 450 decay cycles down to 8'h1F, held in SUSTAIN.
//  3 From SUSTAIN 8'h1F with release=8'hF0, trigger 1->0
//      -> env_out falls linearly over 496 cycles to 0; in_use drops on entering IDLE.
//  4 attack=decay=release=0, sustain=8'hFF, trigger pulse
//      -> attack 256 cycles, DECAY exits immediately, output holds 8'hFF;
//      -> after trigger low, 256 cycles to 0.
//  5 Four units, attack 80/40/20/10, sustain 1F/0F/3F/3F
//      -> each reaches its own sustain independently at the expected cycle counts.
//  6 Retrigger mid-release at env_out=8'h10
//      -> default build restarts from 0; ENV_GEN_LEGATO_EN build rises from 8'h10.

Source files
------------

// File: rtl/env_gen.sv
// Bank of NUM_UNITS linear ADSR envelope generators; env_out/in_use come straight from registers, no backpressure.
// ENV_GEN_LEGATO_EN: retrigger attacks from the current level instead of restarting from zero.
module env_gen #(
  parameter int EG_WIDTH  = 8,
  parameter int NUM_UNITS = 4
) (
  input  logic                          aud_clk,
  input  logic                          aud_rst,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] attack_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] decay_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] sustain_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] release_in,
  input  logic [NUM_UNITS-1:0]          trigger,
  output logic [NUM_UNITS-1:0]          in_use,
  output logic [EG_WIDTH*NUM_UNITS-1:0] env_out
);

  localparam int W  = EG_WIDTH;
  localparam int AW = 2 * EG_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } eg_state_t;

  // Rate 0 is the fastest (2^W per clock), all-ones the slowest (1 per clock).
  function automatic logic [AW-1:0] rate_step(input logic [W-1:0] rate);
    logic [W:0] step;
    step = {1'b1, {W{1'b0}}} - {1'b0, rate};
    return {{(W-1){1'b0}}, step};
  endfunction

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    eg_state_t     state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          trig_q;
    logic          rise, fall;
    logic [AW-1:0] atk_step, dec_step, rel_step;
    logic [AW-1:0] target, retrig_acc;
    logic [AW:0]   atk_sum, dec_lim;

    assign rise     = trigger[i] & ~trig_q;
    assign fall     = ~trigger[i] & trig_q;
    assign atk_step = rate_step(attack_in[W*i +: W]);
    assign dec_step = rate_step(decay_in[W*i +: W]);
    assign rel_step = rate_step(release_in[W*i +: W]);
    assign target   = {sustain_in[W*i +: W], {W{1'b1}}};
    assign atk_sum  = {1'b0, acc_q} + {1'b0, atk_step};
    assign dec_lim  = {1'b0, target} + {1'b0, dec_step};

`ifdef ENV_GEN_LEGATO_EN
    assign retrig_acc = acc_q;
`else
    assign retrig_acc = '0;
`endif

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      case (state_q)
        IDLE: begin
          acc_d = '0;
          if (rise) state_d = ATTACK;
        end
        ATTACK: begin
          if (fall) begin
            state_d = RELEASE;
          end else if (atk_sum >= {1'b0, {AW{1'b1}}}) begin
            acc_d   = '1;
            state_d = DECAY;
          end else begin
            acc_d = atk_sum[AW-1:0];
          end
        end
        DECAY: begin
          if (fall) begin
            state_d = RELEASE;
          end else if (rise) begin
            state_d = ATTACK;
            acc_d   = retrig_acc;
          end else if (acc_q <= target) begin
            state_d = SUSTAIN;
          end else if ({1'b0, acc_q} <= dec_lim) begin
            // Next step would land on or below sustain: clamp instead.
            acc_d   = target;
            state_d = SUSTAIN;
          end else begin
            acc_d = acc_q - dec_step;
          end
        end
        SUSTAIN: begin
          if (fall) begin
            state_d = RELEASE;
          end else if (rise) begin
            state_d = ATTACK;
            acc_d   = retrig_acc;
          end else begin
            acc_d = target;
          end
        end
        RELEASE: begin
          if (rise) begin
            state_d = ATTACK;
            acc_d   = retrig_acc;
          end else if (acc_q < rel_step) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q - rel_step;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
        end
      endcase
    end

    always_ff @(posedge aud_clk or negedge aud_rst) begin
      if (!aud_rst) begin
        state_q <= IDLE;
        acc_q   <= '0;
        trig_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        trig_q  <= trigger[i];
      end
    end

    assign env_out[W*i +: W] = acc_q[AW-1:W];
    assign in_use[i]         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_env_gen.sv
// Directed bench for env_gen: reset, ADSR phases, fastest rates, four independent units, retrigger.
module tb_env_gen;

  logic        aud_clk = 1'b0;
  logic        aud_rst;
  logic [31:0] attack_in, decay_in, sustain_in, release_in;
  logic [3:0]  trigger;
  logic [3:0]  in_use;
  logic [31:0] env_out;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  env_gen #(.EG_WIDTH(8), .NUM_UNITS(4)) dut (
    .aud_clk    (aud_clk),
    .aud_rst    (aud_rst),
    .attack_in  (attack_in),
    .decay_in   (decay_in),
    .sustain_in (sustain_in),
    .release_in (release_in),
    .trigger    (trigger),
    .in_use     (in_use),
    .env_out    (env_out)
  );

  always #5 aud_clk = ~aud_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aud_clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  function automatic logic [7:0] env_u(input int u);
    return env_out[u*8 +: 8];
  endfunction

  int          t5[4] = '{736, 582, 485, 466};
  logic [7:0]  s5[4] = '{8'h1F, 8'h0F, 8'h3F, 8'h3F};

  initial begin
    aud_rst    = 1'b0;
    trigger    = 4'hF;
    attack_in  = '0;
    decay_in   = '0;
    sustain_in = 32'hFFFF_FFFF;
    release_in = '0;

    // Reset holds everything at zero even with all gates high.
    repeat (3) tick();
    chk("rst_env", env_out, 32'h0);
    chk("rst_in_use", {28'h0, in_use}, 32'h0);
    aud_rst = 1'b1;
    tick();
    chk("rst_start_in_use", {28'h0, in_use}, 32'hF);
    chk("rst_start_env", env_out, 32'h0);
    trigger = 4'h0;
    tick();
    chk("rst_fall_in_use", {28'h0, in_use}, 32'hF);
    tick();
    chk("rst_idle_in_use", {28'h0, in_use}, 32'h0);

    // Unit 0: attack 80, decay 80 to sustain 1F.
    attack_in  = 32'h0000_0080;
    decay_in   = 32'h0000_0080;
    sustain_in = 32'h0000_001F;
    release_in = 32'h0000_00F0;
    trigger    = 4'h1;
    tick(); e = 0;
    chk("a2_in_use", {28'h0, in_use}, 32'h1);
    run_to(1);   chk("a2_e1", env_u(0), 8'h00);
    run_to(2);   chk("a2_e2", env_u(0), 8'h01);
    run_to(256); chk("a2_e256", env_u(0), 8'h80);
    run_to(511); chk("a2_e511", env_u(0), 8'hFF);
    run_to(512); chk("a2_e512", env_u(0), 8'hFF);
    run_to(959); chk("d2_e959", env_u(0), 8'h20);
    run_to(960); chk("d2_e960", env_u(0), 8'h1F);
    run_to(970); chk("s2_hold", env_u(0), 8'h1F);
    chk("s2_in_use", {28'h0, in_use}, 32'h1);

    // Release at F0 (step 16) from 1FFF.
    trigger = 4'h0;
    tick(); e = 0;
    chk("r3_f0", env_u(0), 8'h1F);
    run_to(495); chk("r3_f495", env_u(0), 8'h01);
    run_to(496); chk("r3_f496", env_u(0), 8'h00);
    run_to(511); chk("r3_f511_use", {28'h0, in_use}, 32'h1);
    run_to(512); chk("r3_f512_use", {28'h0, in_use}, 32'h0);

    // Fastest rates, sustain FF: decay exits at once.
    attack_in  = 32'h0;
    decay_in   = 32'h0;
    release_in = 32'h0;
    sustain_in = 32'h0000_00FF;
    trigger    = 4'h1;
    tick(); e = 0;
    run_to(128); chk("a4_e128", env_u(0), 8'h80);
    run_to(255); chk("a4_e255", env_u(0), 8'hFF);
    run_to(257); chk("a4_e257_use", {28'h0, in_use}, 32'h1);
    run_to(260); chk("s4_hold", env_u(0), 8'hFF);
    trigger = 4'h0;
    tick(); e = 0;
    chk("r4_f0", env_u(0), 8'hFF);
    run_to(254); chk("r4_f254", env_u(0), 8'h01);
    run_to(255); chk("r4_f255", env_u(0), 8'h00);
    chk("r4_f255_use", {28'h0, in_use}, 32'h1);
    run_to(256); chk("r4_f256_use", {28'h0, in_use}, 32'h0);

    // Four independent units.
    attack_in  = {8'h10, 8'h20, 8'h40, 8'h80};
    sustain_in = {8'h3F, 8'h3F, 8'h0F, 8'h1F};
    decay_in   = 32'h0;
    trigger    = 4'hF;
    tick(); e = 0;
    for (int k = 1; k <= 740; k++) begin
      tick();
      for (int u = 0; u < 4; u++) begin
        if (e == t5[u] - 1) chk($sformatf("m5_u%0d_pre", u), env_u(u), s5[u] + 8'h01);
        if (e == t5[u])     chk($sformatf("m5_u%0d_sus", u), env_u(u), s5[u]);
      end
    end
    chk("m5_all_sus", env_out, 32'h3F3F_0F1F);
    chk("m5_in_use", {28'h0, in_use}, 32'hF);

    // Retrigger unit 0 mid-release at 0x10.
    release_in = 32'hF0F0_F0F0;
    trigger    = 4'h0;
    tick(); e = 0;
    run_to(240); chk("rt6_f240", env_u(0), 8'h10);
    attack_in = {8'h10, 8'h20, 8'h40, 8'h80};
    trigger   = 4'h1;
    tick();
    chk("rt6_use", {31'h0, in_use[0]}, 32'h1);
`ifdef ENV_GEN_LEGATO_EN
    chk("rt6_r0", env_u(0), 8'h10);
    tick(); chk("rt6_r1", env_u(0), 8'h11);
    tick(); chk("rt6_r2", env_u(0), 8'h11);
`else
    chk("rt6_r0", env_u(0), 8'h00);
    tick(); chk("rt6_r1", env_u(0), 8'h00);
    tick(); chk("rt6_r2", env_u(0), 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
